// File: rtl/sdram_arbiter.sv
// Arbitrates video word fetches, CPU byte accesses and boot-loader writes onto one SDRAM port.
// Define SDRAM_ARB_FAIR_EN to stop video from taking two grants in a row while the CPU waits.
module sdram_arbiter #(
    parameter int unsigned ADDR_W = 23
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_ref,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [15:0]       vid_dout,
    output logic              vid_ack,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    input  logic              boot_wr,
    input  logic [ADDR_W-1:0] boot_addr,
    input  logic [7:0]        boot_din,
    output logic              boot_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [15:0]       mem_rdata
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
    state_e state_q, state_d;

    logic [2:0]        gnt_q;  // one-hot {boot, cpu, vid}
    logic [2:0]        ack_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [7:0]        wdata_q;
    logic [15:0]       vid_dout_q;
    logic [7:0]        cpu_dout_q;

    logic              cpu_req, any_req, grant, complete, cpu_first;
    logic [2:0]        pick;
    logic [ADDR_W-1:0] op_addr;
    logic              op_we;
    logic [7:0]        op_wdata;

    assign cpu_req  = cpu_rd | cpu_wr;
    assign any_req  = vid_req | cpu_req | boot_wr;
    // No grant during the ack cycle: the requester just served may still hold its request.
    assign grant    = (state_q == StIdle) && ce_ref && any_req && (ack_q == 3'b000);
    assign complete = (state_q == StWait) && mem_done;

`ifdef SDRAM_ARB_FAIR_EN
    logic fair_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            fair_q <= 1'b0;
        end else if (grant) begin
            fair_q <= pick[0];
        end
    end

    assign cpu_first = fair_q & cpu_req;
`else
    assign cpu_first = 1'b0;
`endif

    always_comb begin
        pick = 3'b000;
        if (cpu_first)    pick = 3'b010;
        else if (vid_req) pick = 3'b001;
        else if (cpu_req) pick = 3'b010;
        else if (boot_wr) pick = 3'b100;
    end

    always_comb begin
        op_addr  = '0;
        op_we    = 1'b0;
        op_wdata = '0;
        unique case (pick)
            3'b001: op_addr = vid_addr;
            3'b010: begin
                op_addr  = cpu_addr;
                op_we    = cpu_wr;
                op_wdata = cpu_din;
            end
            3'b100: begin
                op_addr  = boot_addr;
                op_we    = 1'b1;
                op_wdata = boot_din;
            end
            default: op_addr = '0;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (grant)     state_d = StIssue;
            StIssue: if (mem_ready) state_d = StWait;
            StWait:  if (mem_done)  state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            gnt_q      <= 3'b000;
            ack_q      <= 3'b000;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            vid_dout_q <= '0;
            cpu_dout_q <= '0;
        end else begin
            ack_q <= complete ? gnt_q : 3'b000;
            if (grant) begin
                gnt_q   <= pick;
                addr_q  <= op_addr;
                we_q    <= op_we;
                wdata_q <= op_wdata;
            end
            if (complete && gnt_q[0]) begin
                vid_dout_q <= mem_rdata;
            end
            if (complete && gnt_q[1] && !we_q) begin
                cpu_dout_q <= addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
            end
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == StIssue) begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
    end

    assign vid_ack  = ack_q[0];
    assign cpu_ack  = ack_q[1];
    assign boot_ack = ack_q[2];
    assign vid_dout = vid_dout_q;
    assign cpu_dout = cpu_dout_q;

endmodule
